// File: rtl/inst_fetch_pkg.sv
// Shared CPU constants and types for the fetch stage.
package cpu_defs;
   localparam int          DATA_W           = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

   typedef logic [DATA_W-1:0] word_t;

   function automatic word_t pc_plus_inc(input word_t pc);
      return pc + PC_INC;
   endfunction
endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold freezes all fields.
module if_id_reg
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] cap_pc,
   input  logic [31:0] cap_inst,
   input  logic        cap_adel,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        id_adel
);
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic        valid_q;
   logic        adel_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= '0;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
         adel_q  <= 1'b0;
      end else if (flush) begin
         pc_q    <= '0;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
         adel_q  <= 1'b0;
      end else if (!hold) begin
         pc_q    <= cap_pc;
         inst_q  <= cap_inst;
         valid_q <= 1'b1;
         adel_q  <= cap_adel;
      end
   end

   assign id_pc    = pc_q;
   assign id_inst  = inst_q;
   assign id_valid = valid_q;
   assign id_adel  = adel_q;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, memory enable and next-PC select feeding IF/ID.
// Optional FETCH_ALIGN_CHECK_EN suppresses misaligned fetches and flags id_adel.
module inst_fetch
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   input  logic        exc_en,
   input  logic [31:0] exc_pc,
   output logic        inst_ce,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_data,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        id_adel
);
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic        ce_q;
   logic [31:0] cap_inst;
   logic        cap_adel;

   // ce rises on the first active edge with pc untouched, so RESET_PC is fetched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
         ce_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         ce_q <= 1'b1;
      end
   end

   always_comb begin
      pc_d = pc_q;
      if (ce_q) begin
         if (exc_en)         pc_d = exc_pc;
         else if (stall)     pc_d = pc_q;
         else if (branch_en) pc_d = branch_target;
         else                pc_d = pc_plus_inc(pc_q);
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = ce_q && (pc_q[1:0] != 2'b00);
   assign inst_ce    = ce_q && !misaligned;
   assign cap_inst   = misaligned ? NOP_INST : inst_data;
   assign cap_adel   = misaligned;
`else
   assign inst_ce    = ce_q;
   assign cap_inst   = inst_data;
   assign cap_adel   = 1'b0;
`endif

   assign inst_addr = pc_q;

   if_id_reg u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold     (stall),
      .flush    (!ce_q || exc_en),
      .cap_pc   (pc_q),
      .cap_inst (cap_inst),
      .cap_adel (cap_adel),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .id_valid (id_valid),
      .id_adel  (id_adel)
   );
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: spec-level fetch model checked every cycle plus literal checks.
module tb_inst_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        branch_en = 1'b0;
   logic [31:0] branch_target = '0;
   logic        exc_en = 1'b0;
   logic [31:0] exc_pc = '0;
   logic        inst_ce;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        id_adel;

   int checks = 0;
   int errors = 0;

`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   always #5 clk = ~clk;

   // Word-addressed instruction memory; the low two address bits are ignored.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      logic [31:0] a;
      a = {addr[31:2], 2'b00};
      if (a == 32'h0)      return 32'h0000_f025;
      else if (a == 32'h4) return 32'h241d_1000;
      else                 return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
   endfunction

   assign inst_data = mem_word(inst_addr);

   inst_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .exc_en        (exc_en),
      .exc_pc        (exc_pc),
      .inst_ce       (inst_ce),
      .inst_addr     (inst_addr),
      .inst_data     (inst_data),
      .id_pc         (id_pc),
      .id_inst       (id_inst),
      .id_valid      (id_valid),
      .id_adel       (id_adel)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model of the fetch stage written from the behavioural rules.
   logic [31:0] m_pc;
   logic        m_ce;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_inst;
   logic        m_id_valid;
   logic        m_id_adel;

   function automatic bit m_mis(input logic [31:0] pc);
      return ALIGN && (pc[1:0] != 2'b00);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= 32'h0; m_ce <= 1'b0;
         m_id_pc <= '0; m_id_inst <= '0; m_id_valid <= 1'b0; m_id_adel <= 1'b0;
      end else if (!m_ce || exc_en) begin
         if (m_ce) m_pc <= exc_pc;
         m_ce <= 1'b1;
         m_id_inst <= '0; m_id_valid <= 1'b0; m_id_adel <= 1'b0;
      end else if (!stall) begin
         m_id_pc    <= m_pc;
         m_id_inst  <= m_mis(m_pc) ? 32'h0 : mem_word(m_pc);
         m_id_valid <= 1'b1;
         m_id_adel  <= m_mis(m_pc);
         m_pc       <= branch_en ? branch_target : m_pc + 32'd4;
      end
   end

   always @(negedge clk) begin
      check("m_inst_ce",  {31'b0, inst_ce},  {31'b0, m_ce && !m_mis(m_pc)});
      check("m_inst_addr", inst_addr, m_pc);
      check("m_id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
      check("m_id_inst",  id_inst, m_id_inst);
      check("m_id_adel",  {31'b0, id_adel},  {31'b0, m_id_adel});
      if (m_id_valid) check("m_id_pc", id_pc, m_id_pc);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      check("rst_ce", {31'b0, inst_ce}, 32'h0);
      check("rst_valid", {31'b0, id_valid}, 32'h0);
      check("rst_inst", id_inst, 32'h0);
      check("rst_idpc", id_pc, 32'h0);
      rst_n = 1'b1;
      step;
      check("start_ce", {31'b0, inst_ce}, 32'h1);
      check("start_addr", inst_addr, 32'h0);
      step;
      check("first_inst", id_inst, 32'h0000_f025);
      check("first_pc", id_pc, 32'h0);
      step;
      check("second_inst", id_inst, 32'h241d_1000);
      check("second_pc", id_pc, 32'h4);
      step;
      check("pre_stall_pc", id_pc, 32'h8);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         check("stall_addr", inst_addr, 32'hC);
         check("stall_idpc", id_pc, 32'h8);
      end
      stall = 1'b0;
      step;
      check("unstall_pc0", id_pc, 32'hC);
      step;
      check("unstall_pc1", id_pc, 32'h10);

      for (int i = 0; i < 40 && !(id_valid && id_pc == 32'h40); i++) step;
      check("reach_40", id_pc, 32'h40);
      branch_en = 1'b1; branch_target = 32'h50;
      step;
      branch_en = 1'b0;
      check("br_slot", id_pc, 32'h44);
      check("br_fetch", inst_addr, 32'h50);
      step;
      check("br_tgt", id_pc, 32'h50);
      step;
      check("br_tgt4", id_pc, 32'h54);

      stall = 1'b1; branch_en = 1'b1; branch_target = 32'h100;
      exc_en = 1'b1; exc_pc = 32'hBFC0_0380;
      step;
      stall = 1'b0; branch_en = 1'b0; exc_en = 1'b0;
      check("exc_flush", {31'b0, id_valid}, 32'h0);
      check("exc_addr", inst_addr, 32'hBFC0_0380);
      step;
      check("exc_idpc", id_pc, 32'hBFC0_0380);
      check("exc_valid", {31'b0, id_valid}, 32'h1);

      exc_en = 1'b1; exc_pc = 32'hFFFF_FFFC;
      step;
      exc_en = 1'b0;
      check("wrap_top", inst_addr, 32'hFFFF_FFFC);
      step;
      check("wrap_zero", inst_addr, 32'h0);
      check("wrap_idpc", id_pc, 32'hFFFF_FFFC);
      step;
      #1 rst_n = 1'b0;
      #1;
      check("arst_ce", {31'b0, inst_ce}, 32'h0);
      check("arst_valid", {31'b0, id_valid}, 32'h0);
      check("arst_inst", id_inst, 32'h0);
      check("arst_idpc", id_pc, 32'h0);
      check("arst_addr", inst_addr, 32'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      step;
      check("restart_addr", inst_addr, 32'h0);
      step;
      check("restart_inst", id_inst, 32'h0000_f025);
      branch_en = 1'b1; branch_target = 32'h42;
      step;
      branch_en = 1'b0;
      check("mis_addr", inst_addr, 32'h42);
      check("mis_ce", {31'b0, inst_ce}, ALIGN ? 32'h0 : 32'h1);
      step;
      check("mis_idpc", id_pc, 32'h42);
      check("mis_adel", {31'b0, id_adel}, ALIGN ? 32'h1 : 32'h0);
      check("mis_inst", id_inst, ALIGN ? 32'h0 : mem_word(32'h40));
      check("mis_valid", {31'b0, id_valid}, 32'h1);
      step;
      step;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage and IF/ID pipeline register for the MIPS core. It is the initiating side of the instruction-memory port: it owns the program counter, drives the chip-enable and byte address into instruction memory, and samples the combinationally returned word. Each fetched word is registered together with its PC for the decode stage. Branch redirection honours the MIPS delay slot, and exception redirects take priority over everything else.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and IF/ID register
- branch_en  in  1  ID-stage taken branch or jump; redirect next PC
- branch_target  in  32  redirect address
- exc_en  in  1  exception/eret redirect; flushes IF/ID
- exc_pc  in  32  exception vector or EPC
- inst_ce  out  1  instruction-memory enable
- inst_addr  out  32  byte address to instruction memory (equals current PC)
- inst_data  in  32  instruction word, valid combinationally in the same cycle
- id_pc  out  32  PC of the registered instruction
- id_inst  out  32  registered instruction (32'h0 = NOP when invalid)
- id_valid  out  1  id_inst is a real fetched instruction
- id_adel  out  1  fetch address error on the registered instruction

## Operation
- State: pc (32), ce (1), IF/ID register {id_pc, id_inst, id_valid, id_adel}.
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, ce=0.
  - id_pc=0, id_inst=0, id_valid=0, id_adel=0.
- inst_ce=ce. inst_addr=pc at all times.
- Startup: the first clk edge with rst_n=1 sets ce=1 and leaves pc unchanged, so RESET_PC is the first address fetched.
- Next-PC priority, evaluated only when ce=1:
  1. exc_en: pc<=exc_pc. IF/ID loads NOP with id_valid=0. Overrides stall and branch_en.
  2. stall: pc and IF/ID hold. branch_en is ignored; ID re-asserts it after the stall.
  3. branch_en: pc<=branch_target. IF/ID captures the current fetch, which is the delay slot.
  4. Otherwise: pc<=pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Capture when not stalled and not excepting:
  - id_inst<=inst_data, id_pc<=pc, id_valid<=1.
- When ce=0, IF/ID loads NOP with id_valid=0.

## Timing
- Fetch-to-decode latency is one cycle: the word at address A in cycle n appears on id_inst in cycle n+1.
- Throughput is one instruction per cycle without stalls.
- Branch: branch_en in cycle n (ID holds the branch, IF holds the delay slot) → the delay slot reaches ID in n+1 and branch_target is fetched in n+1. No bubble.
- Exception: exc_en in cycle n → id_valid=0 in n+1, exc_pc fetched in n+1, its instruction in ID in n+2.
- stall held for k cycles → inst_addr and all id_* outputs are frozen for k cycles. The memory read repeats harmlessly.
- Reset asserted mid-operation clears state immediately (asynchronously). The fetch sequence restarts from RESET_PC.

## Configuration
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - When ce=1 and pc[1:0]!=0, inst_ce is driven 0.
  - IF/ID captures id_inst=0, id_pc=pc, id_valid=1, id_adel=1.
  - Downstream raises AdEL with BadVAddr=id_pc.
  - The PC still advances per the normal priority.
- Undefined:
  - id_adel is tied 0.
  - Misaligned addresses are passed to memory unchanged; memory ignores addr[1:0].

## Structure
- Shared package cpu_defs holds:
  - RESET_PC default.
  - NOP_INST = 32'h0000_0000.
  - PC increment constant 4.
  - Data width 32.
- Sub-module if_id_reg holds the IF/ID register with hold/flush controls.
- The PC, ce and next-PC mux live in inst_fetch.

## Test plan
- Reset: rst_n=0 → inst_ce=0, id_valid=0, id_inst=0, id_pc=0. Release → first edge: inst_ce=1, inst_addr=0. Next edge: id_inst=32'h0000f025, id_pc=0. Next edge: id_inst=32'h241d1000, id_pc=4.
- Branch with delay slot: at pc=0x40, assert branch_en=1, branch_target=0x50 for one cycle → id_pc sequence is 0x40, 0x44 (delay slot), 0x50, 0x54.
- Stall: stall=1 for 3 cycles at id_pc=0x8 → inst_addr stays 0xC and id_* are frozen. After release, id_pc=0xC, then 0x10.
- Exception over stall: stall=1, branch_en=1, exc_en=1, exc_pc=0xBFC00380 → next cycle id_valid=0, inst_addr=0xBFC00380. One cycle later id_pc=0xBFC00380.
- Wrap and async reset: force pc=0xFFFFFFFC → next inst_addr=0. Assert rst_n=0 mid-cycle → outputs clear before the next clk edge.
- FETCH_ALIGN_CHECK_EN defined: branch_target=0x42 → inst_ce=0 during that fetch, then id_adel=1, id_pc=0x42, id_inst=0. Macro undefined → id_adel stays 0 and inst_ce=1.
